// File: rtl/shared_imul_arbiter_pkg.sv
// Shared constants for the multiplier-sharing arbiter: FSM encodings, default widths, id width.
package shared_imul_arbiter_pkg;

   localparam int unsigned DEF_NUM_CORES  = 4;
   localparam int unsigned DEF_REQ_NBITS  = 64;
   localparam int unsigned DEF_RESP_NBITS = 32;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   // Width of a core index; never narrower than one bit.
   function automatic int unsigned id_nbits(input int unsigned n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/shared_imul_rr_arb.sv
// Round-robin pick among requesters, starting at a priority pointer that advances past each winner.
// Purely combinational grant; the pointer only moves when the caller reports a fire on update.
module shared_imul_rr_arb
   import shared_imul_arbiter_pkg::*;
#(
   parameter int unsigned p_num      = DEF_NUM_CORES,
   parameter int unsigned p_id_nbits = id_nbits(p_num)
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic [p_num-1:0]      req,
   input  logic                  update,
   output logic [p_num-1:0]      grant,
   output logic [p_id_nbits-1:0] grant_idx
);

   localparam logic [p_id_nbits-1:0] LAST = p_id_nbits'(p_num - 1);

   logic [p_id_nbits-1:0] ptr;
   logic [p_id_nbits-1:0] slot;
   logic                  found;

   // Scan upward from the pointer, wrapping, and keep the first requester seen.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      slot      = '0;
      found     = 1'b0;
      for (int unsigned k = 0; k < p_num; k++) begin
         slot = p_id_nbits'((int'(ptr) + k) % p_num);
         if (!found && req[slot]) begin
            found       = 1'b1;
            grant[slot] = 1'b1;
            grant_idx   = slot;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr <= '0;
      end else if (update) begin
         ptr <= (grant_idx == LAST) ? '0 : grant_idx + p_id_nbits'(1);
      end
   end

endmodule

// File: rtl/shared_imul_arbiter.sv
// Shares one iterative multiplier among p_num_cores cores, one transaction in flight, 0-cycle steering.
// SHARED_IMUL_ARBITER_RESP_BUF_EN adds a one-entry response buffer (+1 cycle) hiding core backpressure.
module shared_imul_arbiter
   import shared_imul_arbiter_pkg::*;
#(
   parameter int unsigned p_num_cores  = DEF_NUM_CORES,
   parameter int unsigned p_req_nbits  = DEF_REQ_NBITS,
   parameter int unsigned p_resp_nbits = DEF_RESP_NBITS
)(
   input  logic                               clk,
   input  logic                               reset,
   input  logic [p_num_cores-1:0]             core_req_val,
   output logic [p_num_cores-1:0]             core_req_rdy,
   input  logic [p_num_cores*p_req_nbits-1:0] core_req_msg,
   output logic [p_num_cores-1:0]             core_resp_val,
   input  logic [p_num_cores-1:0]             core_resp_rdy,
   output logic [p_resp_nbits-1:0]            core_resp_msg,
   output logic                               mulreq_val,
   input  logic                               mulreq_rdy,
   output logic [p_req_nbits-1:0]             mulreq_msg,
   input  logic                               mulresp_val,
   output logic                               mulresp_rdy,
   input  logic [p_resp_nbits-1:0]            mulresp_msg,
   output logic [id_nbits(p_num_cores)-1:0]   grant_id
);

   localparam int unsigned IDW = id_nbits(p_num_cores);

   logic [0:0]             state;
   logic [p_num_cores-1:0] win_oh;
   logic [IDW-1:0]         win_idx;
   logic                   req_open;
   logic                   req_fire;
   logic                   resp_fire;

   shared_imul_rr_arb #(
      .p_num      (p_num_cores),
      .p_id_nbits (IDW)
   ) u_rr (
      .clk       (clk),
      .reset     (reset),
      .req       (core_req_val),
      .update    (req_fire),
      .grant     (win_oh),
      .grant_idx (win_idx)
   );

`ifdef SHARED_IMUL_ARBITER_RESP_BUF_EN
   logic                    buf_full;
   logic [IDW-1:0]          buf_owner;
   logic [p_resp_nbits-1:0] buf_msg;

   // A new grant must wait until the previous product has left the buffer.
   assign req_open = !reset && (state == ST_IDLE) && !buf_full;
`else
   assign req_open = !reset && (state == ST_IDLE);
`endif

   // Request side: steer the winner straight through to the multiplier.
   assign mulreq_val   = req_open && (|core_req_val);
   assign core_req_rdy = (req_open && mulreq_rdy) ? win_oh : '0;
   assign req_fire     = mulreq_val && mulreq_rdy;

   always_comb begin
      mulreq_msg = '0;
      for (int i = 0; i < p_num_cores; i++) begin
         if (win_oh[i]) begin
            mulreq_msg = core_req_msg[i*p_req_nbits +: p_req_nbits];
         end
      end
   end

   assign resp_fire = (state == ST_BUSY) && mulresp_val && mulresp_rdy;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         grant_id <= '0;
      end else if (state == ST_IDLE) begin
         if (req_fire) begin
            state    <= ST_BUSY;
            grant_id <= win_idx;
         end
      end else if (resp_fire) begin
         state <= ST_IDLE;
      end
   end

`ifdef SHARED_IMUL_ARBITER_RESP_BUF_EN
   // While BUSY the buffer is always empty, since a grant cannot fire with it full.
   assign mulresp_rdy   = (state == ST_BUSY) && !buf_full;
   assign core_resp_msg = buf_msg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         buf_full  <= 1'b0;
         buf_owner <= '0;
         buf_msg   <= '0;
      end else begin
         if (resp_fire) begin
            buf_full  <= 1'b1;
            buf_owner <= grant_id;
            buf_msg   <= mulresp_msg;
         end else if (buf_full && core_resp_rdy[buf_owner]) begin
            buf_full <= 1'b0;
         end
      end
   end

   always_comb begin
      core_resp_val = '0;
      if (buf_full) begin
         core_resp_val[buf_owner] = 1'b1;
      end
   end
`else
   // A stalled owner stalls the multiplier: its ready is passed straight back.
   assign mulresp_rdy   = (state == ST_BUSY) && core_resp_rdy[grant_id];
   assign core_resp_msg = mulresp_msg;

   always_comb begin
      core_resp_val = '0;
      if (state == ST_BUSY) begin
         core_resp_val[grant_id] = mulresp_val;
      end
   end
`endif

endmodule

// File: tb/tb_shared_imul_arbiter.sv
// Randomized and directed bench for shared_imul_arbiter against a transaction-level reference model.
`timescale 1ns/1ps
module tb_shared_imul_arbiter;

   localparam int N  = 4;
   localparam int RQ = 64;
   localparam int RS = 32;
   localparam int IW = 2;

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    core_req_val, core_req_rdy, core_resp_val, core_resp_rdy;
   logic [N*RQ-1:0] core_req_msg;
   logic [RS-1:0]   core_resp_msg, mulresp_msg;
   logic            mulreq_val, mulreq_rdy, mulresp_val, mulresp_rdy;
   logic [RQ-1:0]   mulreq_msg;
   logic [IW-1:0]   grant_id;

   always #5 clk = ~clk;

   shared_imul_arbiter #(.p_num_cores(N), .p_req_nbits(RQ), .p_resp_nbits(RS)) dut (
      .clk           (clk),
      .reset         (reset),
      .core_req_val  (core_req_val),
      .core_req_rdy  (core_req_rdy),
      .core_req_msg  (core_req_msg),
      .core_resp_val (core_resp_val),
      .core_resp_rdy (core_resp_rdy),
      .core_resp_msg (core_resp_msg),
      .mulreq_val    (mulreq_val),
      .mulreq_rdy    (mulreq_rdy),
      .mulreq_msg    (mulreq_msg),
      .mulresp_val   (mulresp_val),
      .mulresp_rdy   (mulresp_rdy),
      .mulresp_msg   (mulresp_msg),
      .grant_id      (grant_id)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Core-side stimulus
   bit          pend[N];
   logic [31:0] op0[N], op1[N];
   logic [N-1:0] rdy_drv;
   bit          mul_en;
   int          lat;

   // Reference model: who owns the multiplier and whose turn is next
   int          m_ptr, m_owner;
   bit          m_busy;
   logic [31:0] m_exp;
   bit          b_full;
   int          b_owner;
   logic [31:0] b_prod, b_exp;

   // Behavioural multiplier
   bit          mul_busy;
   int          mul_cnt;
   logic [31:0] mul_prod;

   int ev_grant, ev_resp;

   function automatic bit resp_waiting(input int c);
`ifdef SHARED_IMUL_ARBITER_RESP_BUF_EN
      return b_full && b_owner == c;
`else
      return m_busy && m_owner == c && mul_busy && mul_cnt == 0;
`endif
   endfunction

   function automatic bit any_pend();
      bit a = 0;
      for (int i = 0; i < N; i++) a |= pend[i];
      return a;
   endfunction

   task automatic model_reset();
      m_busy = 0; m_ptr = 0; m_owner = 0; b_full = 0; b_owner = 0;
      mul_busy = 0; mul_cnt = 0;
      for (int i = 0; i < N; i++) pend[i] = 0;
   endtask

   task automatic cycle();
      int           win;
      bit           blocked, e_mreq_val, rfire, pfire, e_mresp_rdy;
      logic [N-1:0] e_req_rdy, e_resp_val;
      logic [31:0]  e_msg;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         core_req_val[i] = pend[i];
         core_req_msg[i*RQ +: RQ] = {op0[i], op1[i]};
      end
      core_resp_rdy = rdy_drv;
      mulreq_rdy    = mul_en && !mul_busy;
      mulresp_val   = mul_busy && mul_cnt == 0;
      mulresp_msg   = mul_busy ? mul_prod : $urandom;
      #1;
      ev_grant = -1;
      ev_resp  = -1;
      win = -1;
      for (int k = 0; k < N; k++)
         if (win < 0 && pend[(m_ptr + k) % N]) win = (m_ptr + k) % N;
      blocked    = m_busy || b_full;
      e_mreq_val = !blocked && win >= 0;
      e_req_rdy  = '0;
      if (e_mreq_val && mulreq_rdy) e_req_rdy[win] = 1'b1;
      e_resp_val  = '0;
      e_mresp_rdy = 0;
      e_msg       = '0;
`ifdef SHARED_IMUL_ARBITER_RESP_BUF_EN
      if (b_full) begin
         e_resp_val[b_owner] = 1'b1;
         e_msg = b_prod;
      end
      e_mresp_rdy = m_busy && !b_full;
`else
      if (m_busy) begin
         if (mulresp_val) e_resp_val[m_owner] = 1'b1;
         e_mresp_rdy = core_resp_rdy[m_owner];
         e_msg = mulresp_msg;
      end
`endif
      chk("mulreq_val", mulreq_val, e_mreq_val);
      chk("core_req_rdy", core_req_rdy, e_req_rdy);
      chk("core_resp_val", core_resp_val, e_resp_val);
      chk("mulresp_rdy", mulresp_rdy, e_mresp_rdy);
      chk("grant_id", grant_id, m_owner);
      if (e_mreq_val) chk("mulreq_msg", mulreq_msg, {op0[win], op1[win]});
      if (e_resp_val != '0) chk("core_resp_msg", core_resp_msg, e_msg);

      rfire = e_mreq_val && mulreq_rdy;
      pfire = m_busy && mulresp_val && e_mresp_rdy;
`ifdef SHARED_IMUL_ARBITER_RESP_BUF_EN
      if (b_full && core_resp_rdy[b_owner]) begin
         chk("resp_prod", core_resp_msg, b_exp);
         ev_resp = b_owner;
         b_full  = 0;
      end
      if (pfire) begin
         b_full = 1; b_owner = m_owner; b_prod = mulresp_msg; b_exp = m_exp;
      end
`else
      if (pfire) begin
         chk("resp_prod", core_resp_msg, m_exp);
         ev_resp = m_owner;
      end
`endif
      if (pfire) begin
         m_busy = 0;
         mul_busy = 0;
      end else if (mul_busy && mul_cnt > 0) begin
         mul_cnt--;
      end
      if (rfire) begin
         m_busy = 1; m_owner = win; m_ptr = (win + 1) % N;
         m_exp = op0[win] * op1[win];
         pend[win] = 0;
         ev_grant = win;
         mul_busy = 1; mul_cnt = lat;
         mul_prod = mulreq_msg[63:32] * mulreq_msg[31:0];
      end
   endtask

   task automatic drain(input string tag);
      int c;
      rdy_drv = '1; mul_en = 1; lat = 2;
      for (c = 0; c < 300; c++) begin
         if (!m_busy && !b_full && !any_pend()) break;
         cycle();
      end
      chk({tag, "_drain"}, c < 300, 1);
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk(tag, {mulreq_val, core_req_rdy, core_resp_val, mulresp_rdy, grant_id}, '0);
   endtask

   int order[5];
   int n, stall, r0, g1;
   bit done, got0, got1;

   initial begin
      reset = 1'b1;
      core_req_val = '1; core_req_msg = '0; core_resp_rdy = '1;
      mulreq_rdy = 1'b1; mulresp_val = 1'b1; mulresp_msg = '0;
      for (int i = 0; i < N; i++) begin op0[i] = 0; op1[i] = 0; end
      model_reset();
      rdy_drv = '1; mul_en = 1; lat = 2;
      #12;
      chk_outputs_zero("reset_outputs");
      core_req_val = '0; mulreq_rdy = 0; mulresp_val = 0;
      @(negedge clk);
      reset = 1'b0;

      // All cores requesting continuously from pointer 0
      for (int i = 0; i < N; i++) begin op0[i] = i + 1; op1[i] = 10; pend[i] = 1; end
      n = 0;
      for (int c = 0; c < 200 && n < 5; c++) begin
         cycle();
         if (ev_grant >= 0) begin order[n] = ev_grant; n++; end
         for (int i = 0; i < N; i++) pend[i] = 1;
      end
      chk("rr_count", n, 5);
      for (int i = 0; i < 5; i++) chk("rr_order", order[i], i % N);
      for (int i = 0; i < N; i++) pend[i] = 0;
      drain("rr");

      // Lone requester, long multiply
      pend[2] = 1; op0[2] = 7; op1[2] = 6; lat = 34;
      done = 0;
      for (int c = 0; c < 150 && !done; c++) begin
         cycle();
         if (ev_grant >= 0) chk("single_grant", core_req_rdy, 4'b0100);
         if (ev_resp >= 0) begin
            chk("single_resp_val", core_resp_val, 4'b0100);
            chk("single_resp_msg", core_resp_msg, 42);
            chk("single_grant_id", grant_id, 2);
            done = 1;
         end
      end
      chk("single_done", done, 1);
      drain("single");

      // Multiplier not ready: nothing may fire and the pointer must hold
      pend[0] = 1; op0[0] = 11; op1[0] = 12;
      pend[1] = 1; op0[1] = 13; op1[1] = 14;
      mul_en = 0;
      for (int c = 0; c < 4; c++) begin
         cycle();
         chk("notrdy_req_rdy", core_req_rdy, 4'b0000);
         chk("notrdy_mulreq_val", mulreq_val, 1);
      end
      mul_en = 1;
      cycle();
      chk("notrdy_winner", core_req_rdy, 4'b0001);
      drain("notrdy");

      // Core 1 stalls its response for 5 cycles; core 2 waits behind it
      pend[1] = 1; op0[1] = 21; op1[1] = 2; lat = 3; stall = 0; done = 0;
      for (int c = 0; c < 100 && !done; c++) begin
         rdy_drv = '1;
         if (resp_waiting(1)) begin rdy_drv[1] = (stall >= 5); stall++; end
         cycle();
         if (ev_grant == 1) begin pend[2] = 1; op0[2] = 4; op1[2] = 4; end
         if (ev_resp == 1) begin
            chk("stall_cycles", stall, 6);
            chk("stall_msg", core_resp_msg, 42);
            done = 1;
         end
      end
      chk("stall_done", done, 1);
      rdy_drv = '1;
      cycle();
      chk("stall_regrant", core_req_rdy, 4'b0100);
      drain("stall");

      // Core 0 response held 3 cycles while core 1 waits to be granted
      pend[0] = 1; op0[0] = 3; op1[0] = 5;
      pend[1] = 1; op0[1] = 9; op1[1] = 9;
      stall = 0; got0 = 0; got1 = 0; r0 = -1; g1 = -1;
      for (int c = 0; c < 200 && !(got0 && got1); c++) begin
         rdy_drv = '1;
         if (resp_waiting(0)) begin rdy_drv[0] = (stall >= 3); stall++; end
         cycle();
         if (ev_grant == 1) g1 = c;
         if (ev_resp == 0) begin chk("buf_prod0", core_resp_msg, 15); got0 = 1; r0 = c; end
         if (ev_resp == 1) begin chk("buf_prod1", core_resp_msg, 81); got1 = 1; end
      end
      chk("buf_done", got0 && got1, 1);
      chk("buf_grant_after_drain", g1 > r0, 1);
      drain("buf");

      // Asynchronous reset in the middle of a transaction
      pend[2] = 1; op0[2] = 2; op1[2] = 3; lat = 10; done = 0;
      for (int c = 0; c < 50 && !done; c++) begin
         cycle();
         if (ev_grant == 2) done = 1;
      end
      cycle();
      #1 reset = 1'b1;
      core_req_val = '1; mulreq_rdy = 1; mulresp_val = 1; core_resp_rdy = '1;
      #1 chk_outputs_zero("async_reset_outputs");
      model_reset();
      core_req_val = '0; mulreq_rdy = 0; mulresp_val = 0;
      @(negedge clk);
      reset = 1'b0;
      pend[1] = 1; op0[1] = 5; op1[1] = 6;
      pend[3] = 1; op0[3] = 7; op1[3] = 8;
      n = 0;
      for (int c = 0; c < 100 && n < 2; c++) begin
         cycle();
         if (ev_grant >= 0) begin
            chk("post_reset_grant", core_req_rdy, (n == 0) ? 4'b0010 : 4'b1000);
            n++;
         end
      end
      chk("post_reset_count", n, 2);
      drain("post_reset");

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && $urandom_range(99) < 30) begin
               pend[i] = 1; op0[i] = $urandom; op1[i] = $urandom;
            end else if (pend[i] && $urandom_range(99) < 4) begin
               pend[i] = 0;
            end
         end
         for (int i = 0; i < N; i++) rdy_drv[i] = ($urandom_range(99) < 75);
         mul_en = ($urandom_range(99) < 85);
         lat = $urandom_range(6);
         cycle();
      end
      drain("random");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
